// File: rtl/lf_field_sched_if.sv
// Config/control and status bundle between the ARM-side config logic and lf_field_sched.
// The master drives configuration and commands; the slave (the scheduler) drives timebase and status.
interface lf_field_sched_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic [7:0]       cfg_div;
  logic [CNT_W-1:0] cfg_on;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_rep;
  logic             start;
  logic             stop;
  logic [7:0]       pck_cnt;
  logic             pck_divclk;
  logic             lf_field;
  logic             sample_stb;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] burst_idx;

  modport master (
    output cfg_div, cfg_on, cfg_gap, cfg_rep, start, stop,
    input  pck_cnt, pck_divclk, lf_field, sample_stb, busy, done, burst_idx
  );

  modport slave (
    input  cfg_div, cfg_on, cfg_gap, cfg_rep, start, stop,
    output pck_cnt, pck_divclk, lf_field, sample_stb, busy, done, burst_idx
  );
endinterface

// File: rtl/lf_field_sched.sv
// LF carrier timebase (pck_cnt / pck_divclk) plus the field-on / gap / repeat sequencer.
// Every output is registered on pck0; state changes are aligned to divclk falling edges.
module lf_field_sched #(
  parameter int DIV_MIN = 15,
  parameter int CNT_W   = 16,
  parameter int REP_W   = 8
) (
  input logic             pck0,
  input logic             nreset,
  lf_field_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ON,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       div_q;
  logic [7:0]       div_pend;
  logic [7:0]       div_clamp;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] on_l;
  logic [CNT_W-1:0] gap_l;
  logic [REP_W-1:0] rep_l;
  logic             wrap;
  logic             tick;
  logic             busy_nxt;

  assign div_clamp = (bus.cfg_div < 8'(DIV_MIN)) ? 8'(DIV_MIN) : bus.cfg_div;
  assign wrap      = (bus.pck_cnt == div_q);
  assign tick      = wrap && bus.pck_divclk;

  // Busy as it will be after this edge; lets busy and sample_stb line up with the state they describe.
  always_comb begin
    busy_nxt = 1'b0;
    if (!bus.stop) begin
      case (state)
        IDLE:    busy_nxt = bus.start;
        DONE:    busy_nxt = 1'b0;
        default: busy_nxt = 1'b1;
      endcase
    end
  end

  // A new divisor is only adopted on a wrap; while busy the value captured at start is used.
  always_ff @(posedge pck0) begin
    if (!nreset) begin
      bus.pck_cnt    <= 8'd0;
      bus.pck_divclk <= 1'b0;
      div_q          <= 8'(DIV_MIN);
      div_pend       <= 8'(DIV_MIN);
    end else begin
      if (state == IDLE) begin
        div_pend <= div_clamp;
      end
      if (wrap) begin
        bus.pck_cnt    <= 8'd0;
        bus.pck_divclk <= ~bus.pck_divclk;
        div_q          <= (state == IDLE) ? div_clamp : div_pend;
      end else begin
        bus.pck_cnt <= bus.pck_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      state          <= IDLE;
      bus.lf_field   <= 1'b0;
      bus.sample_stb <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.burst_idx  <= '0;
      on_cnt         <= '0;
      gap_cnt        <= '0;
      on_l           <= '0;
      gap_l          <= '0;
      rep_l          <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.busy       <= busy_nxt;
      // pck_cnt cannot wrap at 6 because the divisor is at least DIV_MIN.
      bus.sample_stb <= (bus.pck_cnt == 8'd6) && !bus.pck_divclk && busy_nxt;
      if (bus.stop) begin
        state        <= IDLE;
        bus.lf_field <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state <= ARM;
              on_l  <= bus.cfg_on;
              gap_l <= bus.cfg_gap;
              rep_l <= bus.cfg_rep;
            end
          end
          ARM: begin
            if (tick) begin
              state         <= ON;
              bus.lf_field  <= 1'b1;
              on_cnt        <= on_l;
              bus.burst_idx <= '0;
            end
          end
          ON: begin
            if (tick && (on_l != '0)) begin
              if (on_cnt > CNT_W'(1)) begin
                on_cnt <= on_cnt - CNT_W'(1);
              end else if (gap_l != '0) begin
                state        <= GAP;
                gap_cnt      <= gap_l;
                bus.lf_field <= 1'b0;
              end else if (bus.burst_idx == rep_l) begin
                state        <= DONE;
                bus.done     <= 1'b1;
                bus.lf_field <= 1'b0;
              end else begin
                bus.burst_idx <= bus.burst_idx + REP_W'(1);
                on_cnt        <= on_l;
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (gap_cnt > CNT_W'(1)) begin
                gap_cnt <= gap_cnt - CNT_W'(1);
              end else if (bus.burst_idx == rep_l) begin
                state    <= DONE;
                bus.done <= 1'b1;
              end else begin
                state         <= ON;
                bus.lf_field  <= 1'b1;
                bus.burst_idx <= bus.burst_idx + REP_W'(1);
                on_cnt        <= on_l;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state        <= IDLE;
            bus.lf_field <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
